data_memory_responder: RTL and testbench



---
 rtl/data_memory_responder.sv | 177 +++++++++++++++++
 tb/tb_data_memory_responder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_responder
// Description : MEM-stage data-memory responder. DEPTH x 16-bit array with a
//               programmable number of wait states, word/byte loads and
//               stores, pipeline stall generation and fault reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_responder #(
    parameter int DEPTH       = 128,
    parameter int WAIT_STATES = 2
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_req_valid,
    input  logic        i_req_write,
    input  logic        i_req_byte_enable,
    input  logic [15:0] i_req_address,
    input  logic [15:0] i_req_write_data,
    output logic        o_mem_stall,
    output logic        o_resp_valid,
    output logic [15:0] o_read_data,
    output logic        o_addr_error
);

    localparam int          c_IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  c_WAIT_INIT  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [16:0] c_ADDR_LIMIT = 17'(2 * DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RESPOND = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [3:0]  r_count;
    logic        r_write;
    logic        r_byte;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;

    logic [15:0] r_mem [DEPTH];

    logic        r_resp_valid;
    logic [15:0] r_read_data;
    logic        r_addr_error;

    // The access being serviced: when IDLE hands straight to RESPOND (no wait
    // states) the request has not been latched yet, so take it from the port.
    logic              w_from_port;
    logic              w_acc_write;
    logic              w_acc_byte;
    logic [15:0]       w_acc_addr;
    logic [15:0]       w_acc_wdata;
    logic              w_fault;
    logic [c_IDX_W-1:0] w_idx;
    logic [15:0]       w_word;
    logic [7:0]        w_byte_sel;
    logic [15:0]       w_load_data;
    logic [15:0]       w_resp_data;
    logic              w_entering;
    logic              w_commit;

    assign w_from_port = (r_state == S_IDLE);
    assign w_acc_write = w_from_port ? i_req_write       : r_write;
    assign w_acc_byte  = w_from_port ? i_req_byte_enable : r_byte;
    assign w_acc_addr  = w_from_port ? i_req_address     : r_addr;
    assign w_acc_wdata = w_from_port ? i_req_write_data  : r_wdata;

    assign w_fault     = ({1'b0, w_acc_addr} >= c_ADDR_LIMIT) ||
                         (!w_acc_byte && w_acc_addr[0]);
    assign w_idx       = w_acc_addr[c_IDX_W:1];
    assign w_word      = r_mem[w_idx];
    assign w_byte_sel  = w_acc_addr[0] ? w_word[15:8] : w_word[7:0];
    assign w_load_data = w_acc_byte ? {{8{w_byte_sel[7]}}, w_byte_sel} : w_word;
    assign w_resp_data = (w_fault || w_acc_write) ? 16'h0000 : w_load_data;

    assign w_entering  = (w_next_state == S_RESPOND);
    assign w_commit    = w_entering && w_acc_write && !w_fault;

    // State register
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and combinational stall
    always_comb begin
        w_next_state = r_state;
        o_mem_stall  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_req_valid) begin
                    o_mem_stall  = 1'b1;
                    w_next_state = (WAIT_STATES > 0) ? S_WAIT : S_RESPOND;
                end
            end
            S_WAIT: begin
                o_mem_stall = 1'b1;
                if (r_count == 4'd0) begin
                    w_next_state = S_RESPOND;
                end
            end
            S_RESPOND: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Request capture on accept and wait-state countdown
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= 4'd0;
            r_write <= 1'b0;
            r_byte  <= 1'b0;
            r_addr  <= 16'h0000;
            r_wdata <= 16'h0000;
        end else if (r_state == S_IDLE && i_req_valid) begin
            r_count <= c_WAIT_INIT;
            r_write <= i_req_write;
            r_byte  <= i_req_byte_enable;
            r_addr  <= i_req_address;
            r_wdata <= i_req_write_data;
        end else if (r_state == S_WAIT && r_count != 4'd0) begin
            r_count <= r_count - 4'd1;
        end
    end

    // Data array: cleared by reset, stores commit on the edge entering RESPOND
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 16'h0000;
            end
        end else if (w_commit) begin
            if (!w_acc_byte) begin
                r_mem[w_idx] <= w_acc_wdata;
            end else if (w_acc_addr[0]) begin
                r_mem[w_idx][15:8] <= w_acc_wdata[7:0];
            end else begin
                r_mem[w_idx][7:0] <= w_acc_wdata[7:0];
            end
        end
    end

    // Response registers: loaded entering RESPOND, cleared leaving it
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_resp_valid <= 1'b0;
            r_read_data  <= 16'h0000;
            r_addr_error <= 1'b0;
        end else if (w_entering) begin
            r_resp_valid <= 1'b1;
            r_read_data  <= w_resp_data;
            r_addr_error <= w_fault;
        end else begin
            r_resp_valid <= 1'b0;
            r_read_data  <= 16'h0000;
            r_addr_error <= 1'b0;
        end
    end

    assign o_resp_valid = r_resp_valid;
    assign o_read_data  = r_read_data;
    assign o_addr_error = r_addr_error;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory_responder
// Description : Self-checking bench for data_memory_responder. Two instances
//               (2 wait states and 0 wait states) against an array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory_responder;

    localparam int DEPTH = 128;
    localparam int WS_A  = 2;

    logic        clk;
    logic        rst_n;
    logic        req_valid [2];
    logic        req_write [2];
    logic        req_be    [2];
    logic [15:0] req_addr  [2];
    logic [15:0] req_wdata [2];
    logic        stall     [2];
    logic        resp_valid[2];
    logic [15:0] rdata     [2];
    logic        aerr      [2];

    logic [15:0] model [2][DEPTH];

    int n_vec;
    int n_err;

    data_memory_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS_A)) u_dut_a (
        .i_clock          (clk),
        .i_reset_n        (rst_n),
        .i_req_valid      (req_valid[0]),
        .i_req_write      (req_write[0]),
        .i_req_byte_enable(req_be[0]),
        .i_req_address    (req_addr[0]),
        .i_req_write_data (req_wdata[0]),
        .o_mem_stall      (stall[0]),
        .o_resp_valid     (resp_valid[0]),
        .o_read_data      (rdata[0]),
        .o_addr_error     (aerr[0])
    );

    data_memory_responder #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_dut_b (
        .i_clock          (clk),
        .i_reset_n        (rst_n),
        .i_req_valid      (req_valid[1]),
        .i_req_write      (req_write[1]),
        .i_req_byte_enable(req_be[1]),
        .i_req_address    (req_addr[1]),
        .i_req_write_data (req_wdata[1]),
        .o_mem_stall      (stall[1]),
        .o_resp_valid     (resp_valid[1]),
        .o_read_data      (rdata[1]),
        .o_addr_error     (aerr[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run can never hang
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_models();
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < DEPTH; i++)
                model[s][i] = 16'h0000;
    endtask

    task automatic check_idle_outputs(input int sel, input string tag);
        check({tag, ".stall"},  32'(stall[sel]),      32'd0);
        check({tag, ".valid"},  32'(resp_valid[sel]), 32'd0);
        check({tag, ".rdata"},  32'(rdata[sel]),      32'd0);
        check({tag, ".aerr"},   32'(aerr[sel]),       32'd0);
    endtask

    // One complete access. Entry/exit: 1 time unit after a rising edge.
    // hold=1 keeps req_valid high (with scrambled fields during WAIT) until
    // the edge leaving RESPOND, which must all be ignored.
    task automatic access(input int sel, input bit wr, input bit be,
                          input logic [15:0] addr, input logic [15:0] wd,
                          input bit hold, output logic [15:0] got_rd,
                          output logic got_err);
        int          ws;
        bit          exp_err;
        logic [15:0] word;
        logic [15:0] bval;
        logic [15:0] exp_rd;
        int          idx;

        ws      = (sel == 0) ? WS_A : 0;
        exp_err = (int'(addr) >= 2 * DEPTH) || (!be && addr[0]);
        idx     = int'(addr) / 2;
        exp_rd  = 16'h0000;
        if (!exp_err) begin
            word = model[sel][idx];
            bval = (word >> (8 * int'(addr[0]))) & 16'h00FF;
            if (wr) begin
                if (be) begin
                    if (addr[0]) model[sel][idx] = {wd[7:0], word[7:0]};
                    else         model[sel][idx] = {word[15:8], wd[7:0]};
                end else begin
                    model[sel][idx] = wd;
                end
            end else if (be) begin
                exp_rd = (bval >= 16'd128) ? bval + 16'hFF00 : bval;
            end else begin
                exp_rd = word;
            end
        end

        req_valid[sel] = 1'b1;
        req_write[sel] = wr;
        req_be[sel]    = be;
        req_addr[sel]  = addr;
        req_wdata[sel] = wd;
        for (int k = 0; k <= ws; k++) begin
            @(negedge clk);
            check("stall.busy", 32'(stall[sel]),      32'd1);
            check("valid.busy", 32'(resp_valid[sel]), 32'd0);
            @(posedge clk);
            #1;
            if (hold && k < ws) begin
                req_write[sel] = 1'($urandom);
                req_be[sel]    = 1'($urandom);
                req_addr[sel]  = 16'($urandom_range(0, 31));
                req_wdata[sel] = 16'($urandom);
            end else if (!hold) begin
                req_valid[sel] = 1'b0;
            end
        end
        @(negedge clk);
        got_rd  = rdata[sel];
        got_err = aerr[sel];
        check("stall.resp", 32'(stall[sel]),      32'd0);
        check("valid.resp", 32'(resp_valid[sel]), 32'd1);
        check("rdata.resp", 32'(rdata[sel]),      32'(exp_rd));
        check("aerr.resp",  32'(aerr[sel]),       32'(exp_err));
        @(posedge clk);
        #1;
        req_valid[sel] = 1'b0;
        @(negedge clk);
        check_idle_outputs(sel, "after");
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rand_addr();
        case ($urandom % 8)
            0:       return 16'($urandom);
            1:       return 16'($urandom_range(2 * DEPTH - 4, 2 * DEPTH + 3));
            default: return 16'($urandom_range(0, 31));
        endcase
    endfunction

    initial begin
        logic [15:0] rd;
        logic        er;
        n_vec = 0;
        n_err = 0;
        clear_models();
        for (int s = 0; s < 2; s++) begin
            req_valid[s] = 1'b0;
            req_write[s] = 1'b0;
            req_be[s]    = 1'b0;
            req_addr[s]  = 16'h0000;
            req_wdata[s] = 16'h0000;
        end
        rst_n = 1'b0;
        #3;
        check_idle_outputs(0, "reset.a");
        check_idle_outputs(1, "reset.b");
        #17;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed sequence on the 2-wait-state instance
        access(0, 1, 0, 16'h0010, 16'hBEEF, 0, rd, er);
        check("dir.store_rd", 32'(rd), 32'h0000);
        access(0, 0, 0, 16'h0010, 16'h0000, 0, rd, er);
        check("dir.load_beef", 32'(rd), 32'hBEEF);
        access(0, 0, 1, 16'h0011, 16'h0000, 0, rd, er);
        check("dir.byte_hi", 32'(rd), 32'hFFBE);
        access(0, 0, 1, 16'h0010, 16'h0000, 0, rd, er);
        check("dir.byte_lo", 32'(rd), 32'hFFEF);
        access(0, 1, 1, 16'h0011, 16'h0042, 0, rd, er);
        access(0, 0, 0, 16'h0010, 16'h0000, 1, rd, er);
        check("dir.merge", 32'(rd), 32'h42EF);
        access(0, 0, 0, 16'h0003, 16'h0000, 0, rd, er);
        check("dir.misalign_err", 32'(er), 32'd1);
        access(0, 1, 0, 16'h0100, 16'h1234, 0, rd, er);
        check("dir.range_err", 32'(er), 32'd1);
        access(0, 0, 0, 16'h00FE, 16'h0000, 0, rd, er);
        check("dir.last_word", 32'(rd), 32'h0000);
        access(0, 1, 1, 16'h00FF, 16'h0081, 0, rd, er);
        access(0, 0, 1, 16'h00FF, 16'h0000, 0, rd, er);
        check("dir.last_byte", 32'(rd), 32'hFF81);

        // Zero-wait-state instance, request held across RESPOND
        access(1, 1, 0, 16'h0004, 16'h1234, 1, rd, er);
        access(1, 0, 0, 16'h0004, 16'h0000, 1, rd, er);
        check("dir.b_load", 32'(rd), 32'h1234);

        // Randomized traffic on both instances
        for (int n = 0; n < 160; n++) begin
            access(0, 1'($urandom), 1'($urandom), rand_addr(), 16'($urandom),
                   1'($urandom), rd, er);
        end
        for (int n = 0; n < 80; n++) begin
            access(1, 1'($urandom), 1'($urandom), rand_addr(), 16'($urandom),
                   1'($urandom), rd, er);
        end

        // Reset during the wait states of a store
        access(0, 1, 0, 16'h0020, 16'hA5A5, 0, rd, er);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_be[0]    = 1'b0;
        req_addr[0]  = 16'h0020;
        req_wdata[0] = 16'h5A5A;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("rst.in_wait", 32'(stall[0]), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle_outputs(0, "rst.async");
        clear_models();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        access(0, 0, 0, 16'h0020, 16'h0000, 0, rd, er);
        check("rst.cleared", 32'(rd), 32'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
